ctrl_dispatch_fsm: RTL and testbench
====================================

Name: ctrl_dispatch_fsm

Overview:
- Top-level controller stage that sits directly upstream of the per-operation sub-FSMs (get / put / delete).
- Accepts one host command at a time over a valid/ready request channel and decodes the opcode.
- Starts the selected sub-FSM with a one-cycle enter pulse, then holds its enable until that sub-FSM reports done.
- Latches the sub-FSM result and returns it on a valid/ready response channel. A timeout guards against a sub-FSM that never signals done.

Parameters:
- TIMEOUT_CYCLES, 16, maximum cycles in WAIT before the operation is aborted with an error; legal range 2..255.
- CNT_W, $clog2(TIMEOUT_CYCLES+1), width of the internal wait counter; derived, never overridden.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- req_valid  in  1  host command valid.
- req_ready  out  1  controller can accept a command.
- req_op  in  2  opcode: 00 GET, 01 PUT, 10 DEL, 11 illegal.
- sub_enter  out  3  one-hot restart pulse to sub-FSMs; bit0 GET, bit1 PUT, bit2 DEL.
- sub_en  out  3  one-hot enable to the sub-FSMs.
- sub_done  in  3  per-sub-FSM done indication.
- sub_succ  in  3  per-sub-FSM operation-success flag; sampled with done.
- sub_rdy  in  3  per-sub-FSM data-ready flag (hit for GET); sampled with done.
- busy  out  1  high whenever state is not IDLE.
- resp_valid  out  1  response valid.
- resp_ready  in  1  host accepts the response.
- resp_succ  out  1  latched success flag.
- resp_rdy  out  1  latched data-ready / hit flag.
- resp_err  out  1  1 = illegal opcode or timeout.
- resp_op  out  2  opcode of the completed command.

Behaviour:
- States: IDLE, DISPATCH, WAIT, RESP; 2-bit encoding.
- Reset, rst=1 at a clk edge:
  - state=IDLE; wait counter=0.
  - Latched op, resp_succ, resp_rdy and resp_err all 0.
  - Reset overrides every other event, including mid-WAIT and mid-RESP. No enter/en is issued after reset.
- Output values after reset: req_ready=1, busy=0, resp_valid=0, sub_enter=0, sub_en=0.
- Combinational outputs, decoded from state and the latched op:
  - req_ready = (state==IDLE).
  - busy = (state!=IDLE).
  - resp_valid = (state==RESP).
  - sub_enter = onehot(op) only in DISPATCH.
  - sub_en = onehot(op) only in WAIT.
  - Every other bit is 0.
- IDLE, on req_valid&&req_ready:
  - Latch req_op into resp_op.
  - If op != 11 -> DISPATCH.
  - If op == 11 -> RESP with resp_err=1, resp_succ=0, resp_rdy=0; no sub-FSM is touched.
- DISPATCH: exactly one cycle.
  - Asserts sub_enter[op], clears the counter and goes to WAIT.
  - resp_succ, resp_rdy and resp_err are cleared here.
- WAIT: sub_en[op]=1. Only sub_done[op] is observed; done bits of other sub-FSMs are ignored. Each cycle:
  - If sub_done[op]=1: latch resp_succ=sub_succ[op], resp_rdy=sub_rdy[op], resp_err=0; go to RESP.
  - Else if counter==TIMEOUT_CYCLES-1: resp_err=1, resp_succ=0, resp_rdy=0; go to RESP.
  - Else counter+1.
  - Done takes priority over timeout in the same cycle.
- RESP:
  - resp_* fields stay stable while resp_valid=1 and resp_ready=0.
  - On resp_ready=1: go to IDLE.
  - A new request can only be accepted the cycle after returning to IDLE; this one-cycle bubble is intended.
- Minimum latency: request accepted at cycle 0 -> DISPATCH at cycle 1 -> WAIT at cycle 2 (done seen combinationally) -> resp_valid at cycle 3.
- Timeout occurs at cycle 2+TIMEOUT_CYCLES when no done arrives.
- The counter saturates and never wraps, because WAIT always exits at TIMEOUT_CYCLES-1.

Test Plan:
- Reset then GET: after rst, req_valid=1, req_op=00; GET sub-FSM holds done=1, succ=1, rdy=1.
  - Required: sub_enter=001 for exactly one cycle, then sub_en=001 for one cycle.
  - Required: resp_valid at cycle 3 with succ=1, rdy=1, err=0, op=00.
- PUT with 4-cycle delay: sub_done[1] asserted on the 4th WAIT cycle.
  - Required: sub_en=010 for 4 cycles; resp_valid at cycle 6; succ follows sub_succ[1].
- Illegal op: req_op=11.
  - Required: resp_valid one cycle later with err=1, succ=0, rdy=0; sub_enter and sub_en stay 0.
- Timeout: DEL issued with sub_done stuck at 0, TIMEOUT_CYCLES=16.
  - Required: sub_en=100 for exactly 16 cycles, then err=1.
  - Same run with done arriving on cycle 16 -> err=0 (done wins).
- Response backpressure: hold resp_ready=0 for 5 cycles.
  - Required: resp_* stable, req_ready=0, a pending req_valid is not accepted.
  - After resp_ready=1 -> IDLE, and the next request is accepted.
- Reset mid-operation: assert rst in WAIT and again in RESP.
  - Required: next cycle state IDLE, req_ready=1, resp_valid=0, sub_en=0, no spurious sub_enter.

Source files
------------

// File: rtl/ctrl_dispatch_fsm.sv
// ctrl_dispatch_fsm: top-level command dispatcher.
// Accepts one host command at a time, starts the matching get/put/delete
// sub-FSM, waits for its done (bounded by a timeout) and returns the
// latched result on a valid/ready response channel.
module ctrl_dispatch_fsm #(
  parameter  int TIMEOUT_CYCLES = 16,
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  // host request channel
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  // sub-FSM control and status
  output logic [2:0] sub_enter,
  output logic [2:0] sub_en,
  input  logic [2:0] sub_done,
  input  logic [2:0] sub_succ,
  input  logic [2:0] sub_rdy,
  // status / response channel
  output logic       busy,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_succ,
  output logic       resp_rdy,
  output logic       resp_err,
  output logic [1:0] resp_op
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPATCH = 2'd1,
    S_WAIT     = 2'd2,
    S_RESP     = 2'd3
  } state_e;

  localparam logic [1:0]       OP_ILLEGAL = 2'd3;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             succ_q, succ_d;
  logic             rdy_q, rdy_d;
  logic             err_q, err_d;

  logic [2:0]       op_oh;
  logic             done_sel, succ_sel, rdy_sel;

  // One-hot select of the latched opcode; the illegal opcode selects nothing.
  always_comb begin
    case (op_q)
      2'd0:    op_oh = 3'b001;
      2'd1:    op_oh = 3'b010;
      2'd2:    op_oh = 3'b100;
      default: op_oh = 3'b000;
    endcase
  end

  // Only the active sub-FSM's status bits matter; the rest are masked off.
  assign done_sel = |(sub_done & op_oh);
  assign succ_sel = |(sub_succ & op_oh);
  assign rdy_sel  = |(sub_rdy  & op_oh);

  // State and result registers; reset wins over every other event.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      succ_q  <= 1'b0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      succ_q  <= succ_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
    end
  end

  // Next-state, result-latch and decoded-output logic.
  // NOTE: every signal gets a default before the case statement, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    succ_d     = succ_q;
    rdy_d      = rdy_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    busy       = 1'b1;
    resp_valid = 1'b0;
    sub_enter  = 3'b000;
    sub_en     = 3'b000;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          op_d = req_op;
          if (req_op == OP_ILLEGAL) begin
            // Illegal opcode is answered directly; no sub-FSM is started.
            succ_d  = 1'b0;
            rdy_d   = 1'b0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_DISPATCH;
          end
        end
      end

      S_DISPATCH: begin
        sub_enter = op_oh;
        cnt_d     = '0;
        succ_d    = 1'b0;
        rdy_d     = 1'b0;
        err_d     = 1'b0;
        state_d   = S_WAIT;
      end

      S_WAIT: begin
        sub_en = op_oh;
        if (done_sel) begin
          // Done beats a timeout that would expire in the same cycle.
          succ_d  = succ_sel;
          rdy_d   = rdy_sel;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          succ_d  = 1'b0;
          rdy_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          // Always exits at CNT_LAST, so the counter can never wrap.
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign resp_succ = succ_q;
  assign resp_rdy  = rdy_q;
  assign resp_err  = err_q;
  assign resp_op   = op_q;

endmodule

// File: tb/tb_ctrl_dispatch_fsm.sv
// tb_ctrl_dispatch_fsm: directed bench for ctrl_dispatch_fsm.
// Each command is described as a transaction (opcode, WAIT cycle on which
// done arrives, result flags, response hold-off). The expected per-cycle
// output timeline is derived from that description and compared against
// the DUT on every falling edge; literal latencies and flags pin the model.
module tb_ctrl_dispatch_fsm;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [2:0] sub_enter;
  logic [2:0] sub_en;
  logic [2:0] sub_done;
  logic [2:0] sub_succ;
  logic [2:0] sub_rdy;
  logic       busy;
  logic       resp_valid;
  logic       resp_ready;
  logic       resp_succ;
  logic       resp_rdy;
  logic       resp_err;
  logic [1:0] resp_op;

  ctrl_dispatch_fsm #(.TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .sub_enter  (sub_enter),
    .sub_en     (sub_en),
    .sub_done   (sub_done),
    .sub_succ   (sub_succ),
    .sub_rdy    (sub_rdy),
    .busy       (busy),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_succ  (resp_succ),
    .resp_rdy   (resp_rdy),
    .resp_err   (resp_err),
    .resp_op    (resp_op)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected values for the current cycle.
  logic       exp_on = 1'b0;
  logic       exp_req_ready = 1'b1;
  logic       exp_busy = 1'b0;
  logic       exp_valid = 1'b0;
  logic [2:0] exp_enter = 3'b000;
  logic [2:0] exp_en = 3'b000;
  logic       exp_succ = 1'b0;
  logic       exp_rdy = 1'b0;
  logic       exp_err = 1'b0;
  logic [1:0] exp_op = 2'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] onehot(input logic [1:0] op);
    return (op == 2'd3) ? 3'b000 : 3'(1 << op);
  endfunction

  task automatic set_exp(input logic rr, input logic [2:0] ent, input logic [2:0] en, input logic v);
    exp_req_ready = rr;
    exp_busy      = !rr;
    exp_enter     = ent;
    exp_en        = en;
    exp_valid     = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (exp_on) begin
      check("req_ready",  32'(req_ready),  32'(exp_req_ready));
      check("busy",       32'(busy),       32'(exp_busy));
      check("resp_valid", 32'(resp_valid), 32'(exp_valid));
      check("sub_enter",  32'(sub_enter),  32'(exp_enter));
      check("sub_en",     32'(sub_en),     32'(exp_en));
      if (exp_valid) begin
        check("resp_succ", 32'(resp_succ), 32'(exp_succ));
        check("resp_rdy",  32'(resp_rdy),  32'(exp_rdy));
        check("resp_err",  32'(resp_err),  32'(exp_err));
        check("resp_op",   32'(resp_op),   32'(exp_op));
      end
    end
  end

  // Latency monitor: cycle 0 is the cycle whose closing edge accepts a request.
  int   cyc = 0;
  int   acc_cyc = 0;
  int   rv_lat = -1;
  logic rv_prev = 1'b0;

  always @(posedge clk) begin
    if (req_valid && req_ready && !rst) acc_cyc <= cyc;
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (resp_valid && !rv_prev) rv_lat = cyc - acc_cyc;
    rv_prev = resp_valid;
  end

  // One complete command. done_at: WAIT cycle (1-based) carrying done, or
  // 0 / >T for none inside the window. hold: cycles resp_ready stays low.
  task automatic run_txn(input logic [1:0] op, input int done_at, input logic succ,
                         input logic rdy, input int hold, input int lat_lit,
                         input logic err_lit);
    logic [2:0] oh;
    bit         legal;
    bit         hit;
    int         wait_len;
    oh       = onehot(op);
    legal    = (op != 2'd3);
    hit      = legal && (done_at >= 1) && (done_at <= T);
    wait_len = !legal ? 0 : (hit ? done_at : T);
    rv_lat   = -1;

    // IDLE: present the request
    set_exp(1'b1, 3'b000, 3'b000, 1'b0);
    req_valid = 1'b1;
    req_op    = op;
    step();
    req_valid = 1'b0;
    req_op    = 2'd0;

    if (legal) begin
      set_exp(1'b0, oh, 3'b000, 1'b0);
      step();
    end

    // WAIT: other sub-FSMs' status bits are driven opposite to catch misselection
    for (int i = 1; i <= wait_len; i++) begin
      set_exp(1'b0, 3'b000, oh, 1'b0);
      sub_done = ~oh | ((i == done_at) ? oh : 3'b000);
      sub_succ = succ ? oh : ~oh;
      sub_rdy  = rdy  ? oh : ~oh;
      step();
    end
    sub_done = 3'b000;
    sub_succ = 3'b000;
    sub_rdy  = 3'b000;

    // RESP
    set_exp(1'b0, 3'b000, 3'b000, 1'b1);
    exp_succ = hit && succ;
    exp_rdy  = hit && rdy;
    exp_err  = !hit;
    exp_op   = op;
    check("lit_err", 32'(resp_err), 32'(err_lit));
    for (int d = 0; d < hold; d++) begin
      resp_ready = 1'b0;
      req_valid  = 1'b1;
      req_op     = ~op;
      step();
    end
    req_valid  = 1'b0;
    req_op     = 2'd0;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("latency", 32'(rv_lat), 32'(lat_lit));
    set_exp(1'b1, 3'b000, 3'b000, 1'b0);
  endtask

  task automatic reset_in_wait();
    set_exp(1'b1, 3'b000, 3'b000, 1'b0);
    req_valid = 1'b1;
    req_op    = 2'd2;
    step();
    req_valid = 1'b0;
    set_exp(1'b0, 3'b100, 3'b000, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      set_exp(1'b0, 3'b000, 3'b100, 1'b0);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_exp(1'b1, 3'b000, 3'b000, 1'b0);
    step();
    step();
  endtask

  task automatic reset_in_resp();
    set_exp(1'b1, 3'b000, 3'b000, 1'b0);
    req_valid = 1'b1;
    req_op    = 2'd3;
    step();
    req_valid = 1'b0;
    req_op    = 2'd0;
    set_exp(1'b0, 3'b000, 3'b000, 1'b1);
    exp_succ = 1'b0;
    exp_rdy  = 1'b0;
    exp_err  = 1'b1;
    exp_op   = 2'd3;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_exp(1'b1, 3'b000, 3'b000, 1'b0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_resp_op",  32'(resp_op),  32'd0);
    step();
    step();
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_op     = 2'd0;
    sub_done   = 3'b000;
    sub_succ   = 3'b000;
    sub_rdy    = 3'b000;
    resp_ready = 1'b0;
    step();
    step();
    exp_on = 1'b1;
    set_exp(1'b1, 3'b000, 3'b000, 1'b0);
    step();
    rst = 1'b0;
    check("reset_succ", 32'(resp_succ), 32'd0);
    check("reset_rdy",  32'(resp_rdy),  32'd0);
    check("reset_err",  32'(resp_err),  32'd0);
    check("reset_op",   32'(resp_op),   32'd0);
    step();

    // op, done_at, succ, rdy, hold, latency, err
    run_txn(2'd0, 1,  1'b1, 1'b1, 0, 3,  1'b0);  // GET, immediate done
    run_txn(2'd1, 4,  1'b1, 1'b0, 0, 6,  1'b0);  // PUT, done on 4th WAIT cycle
    run_txn(2'd1, 2,  1'b0, 1'b1, 0, 4,  1'b0);  // PUT, failed op
    run_txn(2'd3, 0,  1'b0, 1'b0, 0, 1,  1'b1);  // illegal opcode
    run_txn(2'd2, 0,  1'b1, 1'b1, 0, 18, 1'b1);  // DEL timeout
    run_txn(2'd2, 16, 1'b1, 1'b1, 0, 18, 1'b0);  // DEL, done wins on last cycle
    run_txn(2'd2, 17, 1'b1, 1'b1, 0, 18, 1'b1);  // DEL, done one cycle too late
    run_txn(2'd0, 2,  1'b0, 1'b1, 5, 4,  1'b0);  // GET miss-less hit with backpressure
    run_txn(2'd1, 1,  1'b1, 1'b1, 0, 3,  1'b0);  // next request accepted
    reset_in_wait();
    reset_in_resp();
    run_txn(2'd0, 3,  1'b1, 1'b0, 2, 5,  1'b0);  // GET after resets

    exp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
